secuenciador_registros_vga: RTL

Controller that refreshes the nine display registers feeding the VGA path. On a start pulse it walks slots 0..8, fetches each byte from the data source (PicoBlaze port / RTC interface) over a req/ack handshake, then drives `wr_dir`/`wr_dato` with a one-cycle `wr_en`. `wr_dir` feeds the register-enable decoder's `direccion` input. A second requester, the user edit port, shares the same write path and is granted between slots.

---
 rtl/secuenciador_registros_vga_if.sv | 32 +++
 rtl/secuenciador_registros_vga.sv | 136 +++++++++++++
 2 files changed

// File: rtl/secuenciador_registros_vga_if.sv
// Read, edit and write-path signals of the VGA register sequencer.
// Latency: none, wires only.
// Backpressure: rd_req/rd_ack and edit_req/edit_ack are level request, pulse grant.
interface secuenciador_registros_vga_if;
  logic       inicio;
  logic       rd_req;
  logic [7:0] rd_dir;
  logic       rd_ack;
  logic [7:0] rd_dato;
  logic       edit_req;
  logic [7:0] edit_dir;
  logic [7:0] edit_dato;
  logic       edit_ack;
  logic [7:0] wr_dir;
  logic [7:0] wr_dato;
  logic       wr_en;
  logic       ocupado;
  logic       listo;
  logic       error;

  // Sequencer side
  modport master (
    input  inicio, rd_ack, rd_dato, edit_req, edit_dir, edit_dato,
    output rd_req, rd_dir, edit_ack, wr_dir, wr_dato, wr_en, ocupado, listo, error
  );

  // Data source / user / register bank side
  modport slave (
    output inicio, rd_ack, rd_dato, edit_req, edit_dir, edit_dato,
    input  rd_req, rd_dir, edit_ack, wr_dir, wr_dato, wr_en, ocupado, listo, error
  );
endinterface

// File: rtl/secuenciador_registros_vga.sv
// Refreshes N_REG display registers from a req/ack source and merges user edits on one write path.
// Latency: 3 cycles per slot with immediate ack, +1 per edit, +1 DONE cycle; outputs registered.
// Backpressure: waits up to TIMEOUT cycles per slot for rd_ack; edits held off until between slots.
module secuenciador_registros_vga #(
  parameter int N_REG   = 9,
  parameter int TIMEOUT = 255
) (
  input logic                          clk,
  input logic                          reset,
  secuenciador_registros_vga_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WRITE, NEXT, EDIT, DONE} estado_t;

  localparam logic [7:0] N_B = 8'(N_REG);
  localparam logic [7:0] ULT = 8'(N_REG - 1);
  localparam logic [7:0] TO  = 8'(TIMEOUT);

  estado_t    est, est_nxt;
  logic [7:0] slot, slot_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       pend, pend_nxt;
  logic       desde_next, desde_next_nxt;  // edit origin: 1 = NEXT, 0 = IDLE
  logic       err_nxt;
  logic [7:0] dato_leido;
  logic       esc_lect;
  logic       esc_edit;

  // Next-state and next-value decode; outputs are registered from these values
  always_comb begin
    est_nxt        = est;
    slot_nxt       = slot;
    cnt_nxt        = cnt;
    pend_nxt       = pend;
    desde_next_nxt = desde_next;
    err_nxt        = bus.error;
    dato_leido     = 8'h00;
    esc_lect       = 1'b0;
    case (est)
      IDLE: begin
        if (bus.edit_req) begin
          est_nxt        = EDIT;
          desde_next_nxt = 1'b0;
          if (bus.inicio) pend_nxt = 1'b1;
        end else if (bus.inicio || pend) begin
          est_nxt  = REQ;
          slot_nxt = 8'h00;
          cnt_nxt  = 8'h00;
          pend_nxt = 1'b0;
          err_nxt  = 1'b0;
        end
      end
      REQ: begin
        if (cnt != TO) cnt_nxt = cnt + 8'd1;
        if (bus.rd_ack) begin
          est_nxt    = WRITE;
          dato_leido = bus.rd_dato;
          esc_lect   = 1'b1;
        end else if (cnt == TO - 8'd1) begin
          // Silent source: write a zero so the slot still gets refreshed
          est_nxt    = WRITE;
          dato_leido = 8'h00;
          esc_lect   = 1'b1;
          err_nxt    = 1'b1;
        end
      end
      WRITE: est_nxt = NEXT;
      NEXT: begin
        if (bus.edit_req) begin
          est_nxt        = EDIT;
          desde_next_nxt = 1'b1;
        end else if (slot == ULT) begin
          est_nxt = DONE;
        end else begin
          est_nxt  = REQ;
          slot_nxt = slot + 8'd1;
          cnt_nxt  = 8'h00;
        end
      end
      EDIT:    est_nxt = desde_next ? NEXT : IDLE;
      DONE:    est_nxt = IDLE;
      default: est_nxt = IDLE;
    endcase
  end

  assign esc_edit = (est_nxt == EDIT) && (bus.edit_dir < N_B);

  // Control state: FSM, slot, timeout counter, pending pass, edit origin
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      est        <= IDLE;
      slot       <= 8'h00;
      cnt        <= 8'h00;
      pend       <= 1'b0;
      desde_next <= 1'b0;
    end else begin
      est        <= est_nxt;
      slot       <= slot_nxt;
      cnt        <= cnt_nxt;
      pend       <= pend_nxt;
      desde_next <= desde_next_nxt;
    end
  end

  // Registered outputs, aligned with the state they describe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.rd_req   <= 1'b0;
      bus.rd_dir   <= 8'h00;
      bus.edit_ack <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_dir   <= 8'h00;
      bus.wr_dato  <= 8'h00;
      bus.ocupado  <= 1'b0;
      bus.listo    <= 1'b0;
      bus.error    <= 1'b0;
    end else begin
      bus.rd_req   <= (est_nxt == REQ);
      if (est_nxt == REQ) bus.rd_dir <= slot_nxt;
      bus.edit_ack <= (est_nxt == EDIT);
      bus.wr_en    <= esc_lect || esc_edit;
      if (esc_lect) begin
        bus.wr_dir  <= slot;
        bus.wr_dato <= dato_leido;
      end else if (esc_edit) begin
        bus.wr_dir  <= bus.edit_dir;
        bus.wr_dato <= bus.edit_dato;
      end
      // An edit served straight from IDLE does not count as a busy pass
      bus.ocupado  <= (est_nxt != IDLE) && !((est_nxt == EDIT) && !desde_next_nxt);
      bus.listo    <= (est_nxt == DONE);
      bus.error    <= err_nxt;
    end
  end

endmodule
